// File: rtl/cfs_algn_irq_pkg.sv
// Shared constants and types for the aligner FIFO interrupt controller.
// Error bits 4-7 exist only when CFS_ALGN_IRQ_FIFO_ERR_EN is defined.
package cfs_algn_irq_pkg;

    localparam int STATUS_W = 8;

    localparam int RX_EMPTY_IDX = 0;
    localparam int RX_FULL_IDX  = 1;
    localparam int TX_EMPTY_IDX = 2;
    localparam int TX_FULL_IDX  = 3;
    localparam int RX_OVF_IDX   = 4;
    localparam int RX_UNF_IDX   = 5;
    localparam int TX_OVF_IDX   = 6;
    localparam int TX_UNF_IDX   = 7;

    typedef logic [STATUS_W-1:0] status_t;

endpackage

// File: rtl/cfs_algn_fifo_lvl.sv
// Saturating occupancy counter for one FIFO, with edge events for full/empty.
// Overflow/underflow flags exist only when CFS_ALGN_IRQ_FIFO_ERR_EN is defined.
module cfs_algn_fifo_lvl #(
    parameter  int FIFO_DEPTH = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    output logic [LVL_W-1:0] level,
    output logic             became_full,
    output logic             became_empty
`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
    ,
    output logic             ovf,
    output logic             unf
`endif
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] PRE_FULL = LVL_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    logic push_only;
    logic pop_only;
    logic inc;
    logic dec;

    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign inc       = push_only & (level != FULL_LVL);
    assign dec       = pop_only & (level != '0);

    // Events are judged against the pre-edge level so they land on the same edge as the level.
    assign became_full  = inc & (level == PRE_FULL);
    assign became_empty = dec & (level == ONE_LVL);

`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
    assign ovf = push_only & (level == FULL_LVL);
    assign unf = pop_only & (level == '0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (inc) begin
            level <= level + 1'b1;
        end else if (dec) begin
            level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/cfs_algn_irq_ctrl.sv
// RX/TX occupancy tracking with sticky full/empty status and a masked, registered irq.
// Define CFS_ALGN_IRQ_FIFO_ERR_EN to enable the overflow/underflow status bits 4-7.
module cfs_algn_irq_ctrl
    import cfs_algn_irq_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_fifo_push,
    input  logic                rx_fifo_pop,
    input  logic                tx_fifo_push,
    input  logic                tx_fifo_pop,
    input  logic [STATUS_W-1:0] irq_en,
    input  logic [STATUS_W-1:0] irq_clr,
    output logic [STATUS_W-1:0] irq_status,
    output logic [LVL_W-1:0]    rx_lvl,
    output logic [LVL_W-1:0]    tx_lvl,
    output logic                irq
);

    logic rx_full_ev, rx_empty_ev, tx_full_ev, tx_empty_ev;
`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
    logic rx_ovf, rx_unf, tx_ovf, tx_unf;
`endif

    status_t set_vec;
    status_t status_next;
    logic    irq_next;

    cfs_algn_fifo_lvl #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_lvl (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (rx_fifo_push),
        .pop          (rx_fifo_pop),
        .level        (rx_lvl),
        .became_full  (rx_full_ev),
        .became_empty (rx_empty_ev)
`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
        ,
        .ovf          (rx_ovf),
        .unf          (rx_unf)
`endif
    );

    cfs_algn_fifo_lvl #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_lvl (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (tx_fifo_push),
        .pop          (tx_fifo_pop),
        .level        (tx_lvl),
        .became_full  (tx_full_ev),
        .became_empty (tx_empty_ev)
`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
        ,
        .ovf          (tx_ovf),
        .unf          (tx_unf)
`endif
    );

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        set_vec               = '0;
        set_vec[RX_EMPTY_IDX] = rx_empty_ev;
        set_vec[RX_FULL_IDX]  = rx_full_ev;
        set_vec[TX_EMPTY_IDX] = tx_empty_ev;
        set_vec[TX_FULL_IDX]  = tx_full_ev;
`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
        set_vec[RX_OVF_IDX]   = rx_ovf;
        set_vec[RX_UNF_IDX]   = rx_unf;
        set_vec[TX_OVF_IDX]   = tx_ovf;
        set_vec[TX_UNF_IDX]   = tx_unf;
`endif
        // Set is OR-ed after the clear so a same-cycle set wins.
        status_next = (irq_status & ~irq_clr) | set_vec;
        irq_next    = |(status_next & irq_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= status_next;
            irq        <= irq_next;
        end
    end

endmodule

// File: tb/tb_cfs_algn_irq_ctrl.sv
// Directed plus random bench for cfs_algn_irq_ctrl against a behavioural occupancy/event model.
// Honours CFS_ALGN_IRQ_FIFO_ERR_EN for the expected error bits.
module tb_cfs_algn_irq_ctrl;

    localparam int D     = 8;
    localparam int LVL_W = $clog2(D + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             rx_fifo_push, rx_fifo_pop, tx_fifo_push, tx_fifo_pop;
    logic [7:0]       irq_en, irq_clr;
    logic [7:0]       irq_status;
    logic [LVL_W-1:0] rx_lvl, tx_lvl;
    logic             irq;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_rx, m_tx;
    logic [7:0] m_status;
    logic       m_irq;

    cfs_algn_irq_ctrl #(.FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_fifo_push (rx_fifo_push),
        .rx_fifo_pop  (rx_fifo_pop),
        .tx_fifo_push (tx_fifo_push),
        .tx_fifo_pop  (tx_fifo_pop),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .irq_status   (irq_status),
        .rx_lvl       (rx_lvl),
        .tx_lvl       (tx_lvl),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx_lvl"}, 32'(rx_lvl), 32'(m_rx));
        check({tag, ".tx_lvl"}, 32'(tx_lvl), 32'(m_tx));
        check({tag, ".status"}, 32'(irq_status), 32'(m_status));
        check({tag, ".irq"}, 32'(irq), 32'(m_irq));
    endtask

    function automatic int nxt_lvl(input int lvl, input bit push, input bit pop);
        if (push && !pop) return (lvl < D) ? lvl + 1 : lvl;
        if (pop && !push) return (lvl > 0) ? lvl - 1 : lvl;
        return lvl;
    endfunction

    // Event bits for one FIFO: {unf, ovf, full, empty}
    function automatic logic [3:0] fifo_events(input int lvl, input bit push, input bit pop);
        int n;
        logic [3:0] ev;
        n     = nxt_lvl(lvl, push, pop);
        ev    = '0;
        ev[0] = (lvl != 0) && (n == 0);
        ev[1] = (lvl != D) && (n == D);
`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
        ev[2] = push && !pop && (lvl == D);
        ev[3] = pop && !push && (lvl == 0);
`endif
        return ev;
    endfunction

    task automatic model_reset();
        m_rx = 0; m_tx = 0; m_status = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] rx_ev, tx_ev;
        logic [7:0] set;
        rx_ev = fifo_events(m_rx, rx_fifo_push, rx_fifo_pop);
        tx_ev = fifo_events(m_tx, tx_fifo_push, tx_fifo_pop);
        set   = {tx_ev[3], tx_ev[2], rx_ev[3], rx_ev[2], tx_ev[1], tx_ev[0], rx_ev[1], rx_ev[0]};
        m_rx     = nxt_lvl(m_rx, rx_fifo_push, rx_fifo_pop);
        m_tx     = nxt_lvl(m_tx, tx_fifo_push, tx_fifo_pop);
        m_status = (m_status & ~irq_clr) | set;
        m_irq    = |(m_status & irq_en);
    endtask

    // Drive one cycle of stimulus, let one edge pass, then compare away from the edge.
    task automatic step(input bit rp, input bit rpp, input bit tp, input bit tpp,
                        input logic [7:0] clr, input string tag);
        rx_fifo_push = rp; rx_fifo_pop = rpp;
        tx_fifo_push = tp; tx_fifo_pop = tpp;
        irq_clr      = clr;
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    initial begin
        rx_fifo_push = 0; rx_fifo_pop = 0; tx_fifo_push = 0; tx_fifo_pop = 0;
        irq_en = 8'hFF; irq_clr = 8'h00;
        reset_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_edge();
        check_all("idle");

        // Fill RX: RX_FULL and irq on the 8th edge
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'h00, "rx_fill");
        check("fill.rx_lvl", 32'(rx_lvl), 32'd8);
        check("fill.status", 32'(irq_status), 32'h02);
        check("fill.irq", 32'(irq), 32'd1);

        step(0, 0, 0, 0, 8'h02, "clr_full");
        check("clr.status", 32'(irq_status), 32'h00);
        check("clr.irq", 32'(irq), 32'd0);
        step(1, 0, 0, 0, 8'h00, "rx_over");
        check("over.rx_lvl", 32'(rx_lvl), 32'd8);
`ifdef CFS_ALGN_IRQ_FIFO_ERR_EN
        check("over.status", 32'(irq_status), 32'h10);
`else
        check("over.status", 32'(irq_status), 32'h00);
`endif
        step(0, 0, 0, 0, 8'hFF, "clr_all");

        // TX 0 -> 3 -> 0
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00, "tx_push");
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 8'h00, "tx_pop");
        check("tx_pop.status", 32'(irq_status), 32'h00);
        step(0, 0, 0, 1, 8'h00, "tx_last_pop");
        check("tx_empty.tx_lvl", 32'(tx_lvl), 32'd0);
        check("tx_empty.status", 32'(irq_status), 32'h04);
        step(0, 0, 0, 0, 8'hFF, "clr_all2");

        // Simultaneous push/pop holds the level
        step(0, 0, 1, 0, 8'h00, "tx_to_one");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 8'h00, "tx_pushpop");
        check("pushpop.tx_lvl", 32'(tx_lvl), 32'd1);
        check("pushpop.status", 32'(irq_status), 32'h00);

        // Mask behaviour and set-beats-clear
        step(1, 1, 0, 0, 8'h00, "rx_pushpop_full");
        step(0, 1, 0, 0, 8'h00, "rx_pop7");
        irq_en = 8'h00;
        step(1, 0, 0, 0, 8'h00, "rx_full_masked");
        check("masked.status", 32'(irq_status), 32'h02);
        check("masked.irq", 32'(irq), 32'd0);
        irq_en = 8'h02;
        step(0, 0, 0, 0, 8'h00, "en_change");
        check("en.irq", 32'(irq), 32'd1);
        step(0, 1, 0, 0, 8'h00, "rx_pop7b");
        step(1, 0, 0, 0, 8'h02, "set_beats_clr");
        check("setwins.status", 32'(irq_status), 32'h02);
        check("setwins.irq", 32'(irq), 32'd1);
        irq_en = 8'hFF;

        // Build rx_lvl=5, status=04, then reset mid-burst
        step(0, 0, 0, 0, 8'hFF, "clr_all3");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00, "rx_down");
        step(0, 0, 0, 1, 8'h00, "tx_empty2");
        check("pre_rst.rx_lvl", 32'(rx_lvl), 32'd5);
        check("pre_rst.status", 32'(irq_status), 32'h04);
        rx_fifo_push = 1; irq_clr = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1 reset_n = 1'b1;
        step(1, 0, 0, 0, 8'h00, "post_rst");
        check("post_rst.rx_lvl", 32'(rx_lvl), 32'd1);

        // Random traffic with windows biased towards filling or draining
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 40) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 31) == 0) irq_en = 8'($urandom);
            step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
                 $urandom_range(0, 99) < (100 - bias), $urandom_range(0, 99) >= (100 - bias),
                 ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
